// File: rtl/memwb_skid_stage_if.sv
// One MEM->WB beat bus: valid/ready handshake plus the write-back payload.
// The producer uses the master modport, the consumer the slave modport.
interface memwb_skid_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int WB_W   = 2
) ();
  logic              valid;
  logic              ready;
  logic [WB_W-1:0]   wb;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] reg_data;
  logic [ADDR_W-1:0] reg_addr;

  modport master (output valid, wb, mem_data, reg_data, reg_addr, input ready);
  modport slave  (input valid, wb, mem_data, reg_data, reg_addr, output ready);
endinterface

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and RegWrite gating so bubbles never write back.
module memwb_skid_stage #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int WB_W          = 2,
  parameter bit SKID          = 1'b1,
  parameter bit ZERO_SUPPRESS = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  memwb_skid_stage_if.slave  in_if,
  memwb_skid_stage_if.master out_if,
  output logic reg_write_o,
  output logic mem_to_reg_o
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] reg_data;
    logic [ADDR_W-1:0] reg_addr;
  } beat_t;

  // Encoding doubles as {skid_v, main_v}; FULL is unreachable when SKID=0.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b11
  } state_e;

  state_e state_q, state_d;
  beat_t  main_q, main_d;
  beat_t  skid_q, skid_d;
  beat_t  in_beat;
  logic   valid, ready, in_fire, out_fire;

  assign in_beat = '{wb:       in_if.wb,
                     mem_data: in_if.mem_data,
                     reg_data: in_if.reg_data,
                     reg_addr: in_if.reg_addr};

  assign valid    = (state_q != S_EMPTY);
  // With a skid entry, ready is decoded from state only, breaking the ready_i path.
  assign ready    = SKID ? (state_q != S_FULL) : (!valid || out_if.ready);
  assign in_fire  = in_if.valid && ready;
  assign out_fire = valid && out_if.ready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            main_d  = in_beat;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_beat;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end else if (SKID && in_fire) begin
            skid_d  = in_beat;
            state_d = S_FULL;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst_i) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign in_if.ready     = ready;
  assign out_if.valid    = valid;
  assign out_if.wb       = main_q.wb;
  assign out_if.mem_data = main_q.mem_data;
  assign out_if.reg_data = main_q.reg_data;
  assign out_if.reg_addr = main_q.reg_addr;

  assign reg_write_o  = valid && main_q.wb[0] && (!ZERO_SUPPRESS || (|main_q.reg_addr));
  assign mem_to_reg_o = main_q.wb[1];

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Scoreboard bench: drivers push hand-computed beats when accepted, monitors
// pop and compare whenever a beat leaves either stage instance.
module tb_memwb_skid_stage;

  typedef struct {
    logic [3:0]  wb;
    logic [63:0] mem;
    logic [63:0] rdat;
    logic [4:0]  addr;
    logic        rw;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic flush_i;
  logic rw0, m2r0, rw1, m2r1;

  always #5 clk_i = ~clk_i;

  memwb_skid_stage_if #(.DATA_W(32), .ADDR_W(5), .WB_W(2)) in0 ();
  memwb_skid_stage_if #(.DATA_W(32), .ADDR_W(5), .WB_W(2)) out0 ();
  memwb_skid_stage_if #(.DATA_W(64), .ADDR_W(5), .WB_W(4)) in1 ();
  memwb_skid_stage_if #(.DATA_W(64), .ADDR_W(5), .WB_W(4)) out1 ();

  memwb_skid_stage #(.DATA_W(32), .ADDR_W(5), .WB_W(2), .SKID(1'b1), .ZERO_SUPPRESS(1'b1)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_if(in0), .out_if(out0), .reg_write_o(rw0), .mem_to_reg_o(m2r0));

  memwb_skid_stage #(.DATA_W(64), .ADDR_W(5), .WB_W(4), .SKID(1'b0), .ZERO_SUPPRESS(1'b1)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_if(in1), .out_if(out1), .reg_write_o(rw1), .mem_to_reg_o(m2r1));

  int   errors = 0;
  int   checks = 0;
  int   pops0  = 0;
  int   pops1  = 0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  exp_t e0, e1;

  bit          hold0 = 1'b0;
  logic [31:0] snap_reg0, snap_mem0;
  logic [4:0]  snap_addr0;
  logic [1:0]  snap_wb0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic align();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send0(input logic [1:0] wb, input logic [31:0] md, input logic [31:0] rd,
                       input logic [4:0] ad, input logic rw);
    exp_t e;
    int   n;
    e.wb = 4'(wb); e.mem = 64'(md); e.rdat = 64'(rd); e.addr = ad; e.rw = rw;
    in0.valid = 1'b1; in0.wb = wb; in0.mem_data = md; in0.reg_data = rd; in0.reg_addr = ad;
    n = 0;
    @(negedge clk_i);
    while (!in0.ready && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!in0.ready) begin
      errors++; checks++;
      $display("FAIL send0_timeout: ready_o stayed 0, expected 1 within 50 cycles");
    end else begin
      exp_q0.push_back(e);
    end
    @(posedge clk_i);
    #1;
    in0.valid = 1'b0;
  endtask

  task automatic send1(input logic [3:0] wb, input logic [63:0] md, input logic [63:0] rd,
                       input logic [4:0] ad, input logic rw);
    exp_t e;
    int   n;
    e.wb = wb; e.mem = md; e.rdat = rd; e.addr = ad; e.rw = rw;
    in1.valid = 1'b1; in1.wb = wb; in1.mem_data = md; in1.reg_data = rd; in1.reg_addr = ad;
    n = 0;
    @(negedge clk_i);
    while (!in1.ready && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!in1.ready) begin
      errors++; checks++;
      $display("FAIL send1_timeout: ready_o stayed 0, expected 1 within 50 cycles");
    end else begin
      exp_q1.push_back(e);
    end
    @(posedge clk_i);
    #1;
    in1.valid = 1'b0;
  endtask

  // Monitor for the skid instance: bubble gating, hold stability, scoreboard.
  always @(negedge clk_i) begin
    if (!out0.valid) check("d0_bubble_regwrite", 64'(rw0), 64'd0);
    if (hold0 && out0.valid) begin
      check("d0_hold_reg_data", 64'(out0.reg_data), 64'(snap_reg0));
      check("d0_hold_mem_data", 64'(out0.mem_data), 64'(snap_mem0));
      check("d0_hold_addr", 64'(out0.reg_addr), 64'(snap_addr0));
      check("d0_hold_wb", 64'(out0.wb), 64'(snap_wb0));
    end
    if (out0.valid && out0.ready) begin
      if (exp_q0.size() == 0) begin
        errors++; checks++;
        $display("FAIL d0_unexpected_beat: got reg_data=%h addr=%0d, expected no beat",
                 out0.reg_data, out0.reg_addr);
      end else begin
        e0 = exp_q0.pop_front();
        pops0++;
        check("d0_wb", 64'(out0.wb), 64'(e0.wb));
        check("d0_mem_data", 64'(out0.mem_data), e0.mem);
        check("d0_reg_data", 64'(out0.reg_data), e0.rdat);
        check("d0_reg_addr", 64'(out0.reg_addr), 64'(e0.addr));
        check("d0_regwrite", 64'(rw0), 64'(e0.rw));
        check("d0_memtoreg", 64'(m2r0), 64'(e0.wb[1]));
      end
    end
    hold0      = out0.valid && !out0.ready;
    snap_reg0  = out0.reg_data;
    snap_mem0  = out0.mem_data;
    snap_addr0 = out0.reg_addr;
    snap_wb0   = out0.wb;
  end

  // Monitor for the single-register instance: ready law, bubble gating, scoreboard.
  always @(negedge clk_i) begin
    check("d1_ready_law", 64'(in1.ready), 64'(!out1.valid || out1.ready));
    if (!out1.valid) check("d1_bubble_regwrite", 64'(rw1), 64'd0);
    if (out1.valid && out1.ready) begin
      if (exp_q1.size() == 0) begin
        errors++; checks++;
        $display("FAIL d1_unexpected_beat: got reg_data=%h, expected no beat", out1.reg_data);
      end else begin
        e1 = exp_q1.pop_front();
        pops1++;
        check("d1_wb", 64'(out1.wb), 64'(e1.wb));
        check("d1_mem_data", out1.mem_data, e1.mem);
        check("d1_reg_data", out1.reg_data, e1.rdat);
        check("d1_reg_addr", 64'(out1.reg_addr), 64'(e1.addr));
        check("d1_regwrite", 64'(rw1), 64'(e1.rw));
        check("d1_memtoreg", 64'(m2r1), 64'(e1.wb[1]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [5:0] rdy_pat = 6'b111101;

  initial begin
    rst_i = 1'b1; flush_i = 1'b0;
    in0.valid = 1'b1; in0.wb = 2'b01; in0.mem_data = 32'h11; in0.reg_data = 32'h1000;
    in0.reg_addr = 5'd7; out0.ready = 1'b1;
    in1.valid = 1'b0; in1.wb = '0; in1.mem_data = '0; in1.reg_data = '0; in1.reg_addr = '0;
    out1.ready = 1'b1;

    // Reset with valid_i held high
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", 64'(out0.valid), 64'd0);
    check("rst_regwrite", 64'(rw0), 64'd0);
    check("rst_ready", 64'(in0.ready), 64'd1);
    check("rst_reg_data", 64'(out0.reg_data), 64'd0);
    check("rst_mem_data", 64'(out0.mem_data), 64'd0);
    check("rst_reg_addr", 64'(out0.reg_addr), 64'd0);
    check("rst_wb", 64'(out0.wb), 64'd0);
    check("rst1_valid", 64'(out1.valid), 64'd0);
    check("rst1_reg_data", out1.reg_data, 64'd0);
    rst_i = 1'b0;
    send0(2'b01, 32'h11, 32'h1000, 5'd7, 1'b1);

    // Streaming at full rate
    for (int i = 1; i <= 4; i++)
      send0(2'b01, 32'hC0 + 32'(i), 32'h10 * 32'(i), 5'(i), 1'b1);
    @(negedge clk_i);
    #1;
    check("stream_pops", 64'(pops0), 64'd5);
    check("stream_drained", 64'(exp_q0.size()), 64'd0);

    // Back-pressure fills main and skid
    align();
    out0.ready = 1'b0;
    send0(2'b01, 32'h0, 32'hAAAA, 5'd10, 1'b1);
    send0(2'b01, 32'h0, 32'hBBBB, 5'd11, 1'b1);
    @(negedge clk_i);
    #1;
    check("bp_ready_low", 64'(in0.ready), 64'd0);
    check("bp_hold_a", 64'(out0.reg_data), 64'hAAAA);
    repeat (2) @(negedge clk_i);
    align();
    out0.ready = 1'b1;
    @(negedge clk_i);
    #1;
    check("bp_ready_still_low", 64'(in0.ready), 64'd0);
    @(negedge clk_i);
    #1;
    check("bp_ready_back", 64'(in0.ready), 64'd1);
    check("bp_pops", 64'(pops0), 64'd7);
    check("bp_drained", 64'(exp_q0.size()), 64'd0);

    // Flush while FULL, with a beat presented
    align();
    out0.ready = 1'b0;
    send0(2'b01, 32'h0, 32'hA1A1, 5'd12, 1'b1);
    send0(2'b01, 32'h0, 32'hB1B1, 5'd13, 1'b1);
    flush_i = 1'b1;
    in0.valid = 1'b1; in0.wb = 2'b01; in0.reg_data = 32'hCCCC; in0.reg_addr = 5'd14;
    @(negedge clk_i);
    check("fl_full_ready", 64'(in0.ready), 64'd0);
    exp_q0.delete();
    @(posedge clk_i);
    #1;
    flush_i = 1'b0; in0.valid = 1'b0; out0.ready = 1'b1;
    @(negedge clk_i);
    #1;
    check("fl_valid_low", 64'(out0.valid), 64'd0);
    check("fl_regwrite_low", 64'(rw0), 64'd0);
    check("fl_ready_high", 64'(in0.ready), 64'd1);
    repeat (3) @(negedge clk_i);

    // Flush in ONE while an accepted beat is presented
    align();
    out0.ready = 1'b0;
    send0(2'b01, 32'h0, 32'hD0D0, 5'd15, 1'b1);
    flush_i = 1'b1;
    in0.valid = 1'b1; in0.reg_data = 32'hE0E0; in0.reg_addr = 5'd16;
    @(negedge clk_i);
    check("fl1_ready", 64'(in0.ready), 64'd1);
    exp_q0.delete();
    @(posedge clk_i);
    #1;
    flush_i = 1'b0; in0.valid = 1'b0; out0.ready = 1'b1;
    @(negedge clk_i);
    #1;
    check("fl1_valid_low", 64'(out0.valid), 64'd0);
    repeat (3) @(negedge clk_i);

    // Zero-register suppression and MemtoReg-only beat
    align();
    send0(2'b11, 32'hDEADBEEF, 32'h5555, 5'd0, 1'b0);
    send0(2'b10, 32'h1234, 32'h6666, 5'd3, 1'b0);
    @(negedge clk_i);
    #1;
    check("zero_drained", 64'(exp_q0.size()), 64'd0);
    check("zero_pops", 64'(pops0), 64'd9);

    // Single-register instance with ready_i toggling under continuous input
    align();
    fork
      begin
        send1(4'b1001, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 5'd1, 1'b1);
        send1(4'b1001, 64'h1, 64'h0123456789ABCDF0, 5'd2, 1'b1);
        send1(4'b0110, 64'h2, 64'h8000000000000001, 5'd3, 1'b0);
        send1(4'b1011, 64'h3, 64'hFFFFFFFF00000000, 5'd0, 1'b0);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          out1.ready = rdy_pat[i];
          align();
        end
        out1.ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk_i);
    #1;
    check("d1_pops", 64'(pops1), 64'd4);
    check("d1_drained", 64'(exp_q1.size()), 64'd0);
    check("d0_final_drained", 64'(exp_q0.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memwb_skid_stage.md
Name: memwb_skid_stage

Overview:
Parametrised successor to the MEM/WB pipeline register. Carries write-back control, memory data, ALU result and destination register from the MEM stage to the WB stage. Adds a valid/ready handshake with an optional 2-entry skid buffer, synchronous flush, and bubble-safe RegWrite gating. Lets a multi-cycle memory or a stalled WB stage back-pressure MEM without losing or duplicating instructions.

Parameters:
DATA_W, 32, width of MemData and RegData
ADDR_W, 5, width of the register address
WB_W, 2, width of the WB control bundle (bit0=RegWrite, bit1=MemtoReg, bits above pass through); minimum 2
SKID, 1, 1 = 2-entry skid buffer (full throughput under back-pressure); 0 = single register, ready_o = ~valid_o | ready_i
ZERO_SUPPRESS, 1, 1 = force RegWrite_o low when RegAddr_o == 0

Ports:
clk_i  input  1  clock, all state updates on posedge
rst_i  input  1  reset, synchronous, active-high
flush_i  input  1  kill all held entries and the current input beat
valid_i  input  1  MEM stage presents a beat
ready_o  output  1  stage can accept a beat this cycle
WB_i  input  WB_W  write-back control bundle
MemData_i  input  DATA_W  load data
RegData_i  input  DATA_W  ALU/result data
RegAddr_i  input  ADDR_W  destination register
valid_o  output  1  output beat valid
ready_i  input  1  WB stage consumes the beat
WB_o  output  WB_W  registered control bundle
RegWrite_o  output  1  WB_o[0] & valid_o (& RegAddr_o!=0 if ZERO_SUPPRESS)
MemtoReg_o  output  1  WB_o[1]
MemData_o  output  DATA_W  registered load data
RegData_o  output  DATA_W  registered result data
RegAddr_o  output  ADDR_W  registered destination

Behaviour:
- Handshake terms: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- Reset (rst_i=1 at posedge): main_v=0, skid_v=0, and all data/control registers cleared to 0. After reset, valid_o=0, RegWrite_o=0, every data output 0, ready_o=1. Reset has priority over flush and every other input.
- SKID=1 storage: main register (drives outputs) plus skid register. ready_o = ~skid_v, a pure register output with no combinational path from ready_i.
- SKID=1 transitions (main_v, skid_v):
  - EMPTY (0,0): in_fire loads main and moves to ONE.
  - ONE (1,0):
    - out_fire & in_fire: main <= input, stay in ONE.
    - out_fire only: go to EMPTY.
    - in_fire only: skid <= input, go to FULL.
  - FULL (1,1): ready_o=0. On out_fire, main <= skid and go to ONE.
- SKID=0: single register. ready_o = ~valid_o | ready_i (combinational). Load on in_fire; clear valid on out_fire without in_fire.
- Latency: 1 cycle from in_fire to valid_o in the EMPTY state. Order is strictly FIFO. No beat is dropped or duplicated except by flush.
- Flush (flush_i=1, rst_i=0): next cycle main_v=0 and skid_v=0. The beat presented that cycle is discarded even if in_fire. Data registers keep stale values. RegWrite_o is 0 while valid_o=0.
- Output data is stable while valid_o & ~ready_i, and changes only on out_fire, flush, or reset.
- RegWrite_o must never be 1 when valid_o=0, so bubbles cannot write the register file.
- ZERO_SUPPRESS=1: RegWrite_o=0 whenever RegAddr_o==0, regardless of WB_o[0].
- WB_o passes all WB_W bits unmodified; only RegWrite_o is gated.
- No simulation-only display or print statements in the RTL.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles with valid_i=1 -> valid_o=0, RegWrite_o=0, ready_o=1, all data outputs 0; first beat accepted on the cycle after rst_i drops.
- Streaming: ready_i=1, 4 beats with RegAddr 1..4, RegData 0x10..0x40, WB_i=2'b01 -> same beats out in order one cycle later, one per cycle, RegWrite_o=1 on each.
- Back-pressure (SKID=1): ready_i=0 while sending beats A=0xAAAA and B=0xBBBB -> ready_o falls after B, outputs hold A; raise ready_i -> A then B on consecutive cycles, ready_o returns to 1, no loss.
- Flush in FULL: stage holds A and B, assert flush_i with valid_i=1 carrying C -> next cycle valid_o=0, RegWrite_o=0; A, B and C never appear on the output.
- Zero register: beat with RegAddr_i=0, WB_i=2'b11, MemData_i=0xDEADBEEF -> valid_o=1, MemtoReg_o=1, MemData_o=0xDEADBEEF, RegWrite_o=0 (ZERO_SUPPRESS=1).
- SKID=0, DATA_W=64, WB_W=4: ready_i toggled 1,0,1 with continuous input -> ready_o equals ~valid_o|ready_i each cycle; WB_o[3:2]=2'b10 passes through; 64-bit RegData 0x0123456789ABCDEF intact.
